// File: rtl/mem_access_unit.sv
// Data-memory access unit for the M stage. Takes one load/store per handshake,
// drives an aligned word bus with byte enables, optionally splits misaligned
// half/word accesses into two aligned beats, and returns extended load data or
// an AdEL/AdES/DBE exception pulse.
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int SPLIT_MISALIGN = 1,
    parameter int TIMEOUT        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              exc_valid,
    output logic [4:0]        exc_code,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [4:0] EXC_ADEL  = 5'd4;
    localparam logic [4:0] EXC_ADES  = 5'd5;
    localparam logic [4:0] EXC_DBE   = 5'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_WAIT1,
        S_REQ2,
        S_WAIT2,
        S_FAULT
    } state_t;

    // Opcodes 0..4 are loads, 5..7 stores.
    function automatic logic is_load(input logic [2:0] op);
        return op < 3'd5;
    endfunction

    // Access size in bytes.
    function automatic logic [2:0] size_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 3'd1;
            3'd2, 3'd3, 3'd6: return 3'd2;
            default:          return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(input logic [2:0] op);
        case (size_of(op))
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        return ((size_of(op) == 3'd2) && off[0]) || ((size_of(op) == 3'd4) && (off != 2'd0));
    endfunction

    // A misaligned access crossing the word boundary needs a second beat.
    function automatic logic two_beat(input logic [2:0] op, input logic [1:0] off);
        return misaligned(op, off) && (({1'b0, off} + size_of(op)) > 3'd4);
    endfunction

    function automatic logic [31:0] trunc_wdata(input logic [2:0] op, input logic [31:0] wd);
        case (size_of(op))
            3'd1:    return {24'b0, wd[7:0]};
            3'd2:    return {16'b0, wd[15:0]};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] op, input logic [31:0] w);
        case (op)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {24'b0, w[7:0]};
            3'd2:    return {{16{w[15]}}, w[15:0]};
            3'd3:    return {16'b0, w[15:0]};
            3'd4:    return w;
            default: return 32'b0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       rdata1_q, rdata1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic              exc_valid_q, exc_valid_d;
    logic [4:0]        exc_code_q, exc_code_d;

    logic [1:0]        off;
    logic [7:0]        be64;
    logic [63:0]       wd64;
    logic [ADDR_W-1:0] addr1, addr2;
    logic [63:0]       rd64;
    logic [31:0]       rd_aligned;
    logic [31:0]       resp_word;
    logic              timed_out;

    // Lane maths for the latched request and load-data assembly.
    always_comb begin
        off        = addr_q[1:0];
        be64       = {4'b0000, mask_of(op_q)} << off;
        wd64       = {32'b0, trunc_wdata(op_q, wdata_q)} << {off, 3'b000};
        addr1      = {addr_q[ADDR_W-1:2], 2'b00};
        addr2      = addr1 + ADDR_W'(4);
        rd64       = (state_q == S_WAIT2) ? {mem_rdata, rdata1_q} : {32'b0, mem_rdata};
        rd_aligned = 32'(rd64 >> {off, 3'b000});
        resp_word  = is_load(op_q) ? extend_load(op_q, rd_aligned) : 32'b0;
        timed_out  = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Next-state and registered response/exception logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        rdata1_d     = rdata1_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'b0;
        resp_rd_d    = 5'b0;
        exc_valid_d  = 1'b0;
        exc_code_d   = 5'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    cnt_d   = '0;
                    if ((SPLIT_MISALIGN == 0) && misaligned(req_op, req_addr[1:0])) begin
                        state_d     = S_FAULT;
                        exc_valid_d = 1'b1;
                        exc_code_d  = is_load(req_op) ? EXC_ADEL : EXC_ADES;
                    end else begin
                        state_d = S_REQ1;
                    end
                end
            end
            S_REQ1, S_REQ2: begin
                // A grant on the last allowed cycle cannot be followed by
                // rvalid in time, so the timeout wins.
                if (timed_out) begin
                    state_d     = S_IDLE;
                    exc_valid_d = 1'b1;
                    exc_code_d  = EXC_DBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (mem_gnt) begin
                        state_d = (state_q == S_REQ1) ? S_WAIT1 : S_WAIT2;
                    end
                end
            end
            S_WAIT1, S_WAIT2: begin
                // rvalid on the timeout cycle still completes the beat.
                if (mem_rvalid) begin
                    if ((state_q == S_WAIT1) && two_beat(op_q, off)) begin
                        state_d  = S_REQ2;
                        rdata1_d = mem_rdata;
                        cnt_d    = '0;
                    end else begin
                        state_d      = S_IDLE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = resp_word;
                        resp_rd_d    = is_load(op_q) ? rd_q : 5'b0;
                    end
                end else if (timed_out) begin
                    state_d     = S_IDLE;
                    exc_valid_d = 1'b1;
                    exc_code_d  = EXC_DBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, request latches and output pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 3'b0;
            addr_q       <= '0;
            wdata_q      <= 32'b0;
            rd_q         <= 5'b0;
            rdata1_q     <= 32'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'b0;
            resp_rd_q    <= 5'b0;
            exc_valid_q  <= 1'b0;
            exc_code_q   <= 5'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            rdata1_q     <= rdata1_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            exc_valid_q  <= exc_valid_d;
            exc_code_q   <= exc_code_d;
        end
    end

    // Bus outputs are forced to zero outside the request states.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        mem_req    = (state_q == S_REQ1) || (state_q == S_REQ2);
        mem_we     = mem_req && !is_load(op_q);
        mem_be     = 4'b0;
        mem_addr   = '0;
        mem_wdata  = 32'b0;
        if (state_q == S_REQ1) begin
            mem_be    = be64[3:0];
            mem_addr  = addr1;
            mem_wdata = wd64[31:0];
        end else if (state_q == S_REQ2) begin
            mem_be    = be64[7:4];
            mem_addr  = addr2;
            mem_wdata = wd64[63:32];
        end
        resp_valid = resp_valid_q;
        resp_data  = resp_data_q;
        resp_rd    = resp_rd_q;
        exc_valid  = exc_valid_q;
        exc_code   = exc_code_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one split-enabled instance for bus
// behaviour and one split-disabled instance for address exceptions.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        rv_a, rv_b;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready_a, resp_valid_a, exc_valid_a, mem_req_a, mem_we_a;
    logic [31:0] resp_data_a, mem_addr_a, mem_wdata_a;
    logic [4:0]  resp_rd_a, exc_code_a;
    logic [3:0]  mem_be_a;

    logic        req_ready_b, resp_valid_b, exc_valid_b, mem_req_b, mem_we_b;
    logic [31:0] resp_data_b, mem_addr_b, mem_wdata_b;
    logic [4:0]  resp_rd_b, exc_code_b;
    logic [3:0]  mem_be_b;

    int passed = 0;
    int total  = 0;
    int hi_cnt;

    mem_access_unit #(.ADDR_W(32), .SPLIT_MISALIGN(1), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(req_ready_a),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid_a), .resp_data(resp_data_a), .resp_rd(resp_rd_a),
        .exc_valid(exc_valid_a), .exc_code(exc_code_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_be(mem_be_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.ADDR_W(32), .SPLIT_MISALIGN(0), .TIMEOUT(16)) dut_ns (
        .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(req_ready_b),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_rd(resp_rd_b),
        .exc_valid(exc_valid_b), .exc_code(exc_code_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_be(mem_be_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request on instance A; returns in cycle 1 (first REQ1 cycle).
    task automatic issue_a(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
        rv_a = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
        tick();
        rv_a = 1'b0;
    endtask

    // Grant now, rvalid with data on the following cycle.
    task automatic beat(input logic [31:0] rdata);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    initial begin
        reset = 1'b1; rv_a = 1'b0; rv_b = 1'b0;
        req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        chk("rst_ready_a", req_ready_a, 1'b1);
        chk("rst_ready_b", req_ready_b, 1'b1);
        chk("rst_outs", {resp_valid_a, exc_valid_a, mem_req_a, mem_we_a, mem_be_a}, 8'h00);
        chk("rst_addr", mem_addr_a, 32'h0);
        reset = 1'b0;
        tick();

        // lb 0x103 -> byte lane 3, sign-extended, response in cycle 3
        issue_a(3'd0, 32'h103, 32'h0, 5'd5);
        chk("lb_req", mem_req_a, 1'b1);
        chk("lb_addr", mem_addr_a, 32'h100);
        chk("lb_be", mem_be_a, 4'b1000);
        chk("lb_we", mem_we_a, 1'b0);
        chk("lb_busy", req_ready_a, 1'b0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
        chk("lb_c2_noresp", resp_valid_a, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        chk("lb_c3_valid", resp_valid_a, 1'b1);
        chk("lb_data", resp_data_a, 32'hFFFF_FF80);
        chk("lb_rd", resp_rd_a, 5'd5);
        tick();
        chk("lb_pulse", resp_valid_a, 1'b0);

        // sh 0x202 -> upper half lanes
        issue_a(3'd6, 32'h202, 32'hAAAA_BEEF, 5'd7);
        chk("sh_we", mem_we_a, 1'b1);
        chk("sh_be", mem_be_a, 4'b1100);
        chk("sh_wdata", mem_wdata_a, 32'hBEEF_0000);
        chk("sh_addr", mem_addr_a, 32'h200);
        beat(32'hDEAD_BEEF);
        chk("sh_valid", resp_valid_a, 1'b1);
        chk("sh_data", resp_data_a, 32'h0);
        chk("sh_rd", resp_rd_a, 5'd0);
        tick();

        // lw 0x301 split into two beats
        issue_a(3'd4, 32'h301, 32'h0, 5'd9);
        chk("lw_b1_addr", mem_addr_a, 32'h300);
        chk("lw_b1_be", mem_be_a, 4'b1110);
        beat(32'h4433_2211);
        chk("lw_b2_req", mem_req_a, 1'b1);
        chk("lw_b2_addr", mem_addr_a, 32'h304);
        chk("lw_b2_be", mem_be_a, 4'b0001);
        chk("lw_mid_noresp", resp_valid_a, 1'b0);
        beat(32'h8877_6655);
        chk("lw_valid", resp_valid_a, 1'b1);
        chk("lw_data", resp_data_a, 32'h5544_3322);
        chk("lw_rd", resp_rd_a, 5'd9);
        tick();

        // sw 0x303 split store: lanes and data of both beats
        issue_a(3'd7, 32'h303, 32'h1122_3344, 5'd1);
        chk("sw_b1_be", mem_be_a, 4'b1000);
        chk("sw_b1_wd", mem_wdata_a, 32'h4400_0000);
        beat(32'h0);
        chk("sw_b2_be", mem_be_a, 4'b0111);
        chk("sw_b2_wd", mem_wdata_a, 32'h0011_2233);
        chk("sw_b2_addr", mem_addr_a, 32'h304);
        beat(32'h0);
        chk("sw_valid", {resp_valid_a, exc_valid_a}, 2'b10);
        tick();

        // split disabled: lhu 0x1 -> AdEL, no bus activity
        rv_b = 1'b1; req_op = 3'd3; req_addr = 32'h1;
        tick();
        rv_b = 1'b0;
        chk("adel_exc", exc_valid_b, 1'b1);
        chk("adel_code", exc_code_b, 5'd4);
        chk("adel_noreq", mem_req_b, 1'b0);
        chk("adel_noresp", resp_valid_b, 1'b0);
        tick();
        chk("adel_pulse", {exc_valid_b, mem_req_b, req_ready_b}, 3'b001);
        rv_b = 1'b1; req_op = 3'd7; req_addr = 32'h2;
        tick();
        rv_b = 1'b0;
        chk("ades_code", {exc_valid_b, exc_code_b}, {1'b1, 5'd5});
        chk("ades_noreq", mem_req_b, 1'b0);
        tick();

        // sw 0x0 with gnt held low -> DBE after 16 request cycles
        issue_a(3'd7, 32'h0, 32'h1234_5678, 5'd0);
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (mem_req_a) hi_cnt++;
            tick();
        end
        chk("to_req_cycles", hi_cnt, 16);
        chk("to_exc", {exc_valid_a, exc_code_a}, {1'b1, 5'd7});
        chk("to_ready", req_ready_a, 1'b1);
        chk("to_noreq", mem_req_a, 1'b0);
        tick();
        chk("to_pulse", exc_valid_a, 1'b0);

        // reset in WAIT2 of a split lh, then a stray rvalid
        issue_a(3'd2, 32'h3, 32'h0, 5'd4);
        beat(32'hCD00_0000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", req_ready_a, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AB;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rv_quiet", {resp_valid_a, exc_valid_a, mem_req_a}, 3'b000);
        chk("late_rv_data", resp_data_a, 32'h0);
        tick();
        chk("late_rv_quiet2", {resp_valid_a, exc_valid_a, mem_req_a}, 3'b000);

        // lbu 0x102 afterwards completes normally
        issue_a(3'd1, 32'h102, 32'h0, 5'd3);
        chk("lbu_be", mem_be_a, 4'b0100);
        chk("lbu_addr", mem_addr_a, 32'h100);
        beat(32'h80FF_1234);
        chk("lbu_valid", resp_valid_a, 1'b1);
        chk("lbu_data", resp_data_a, 32'h0000_00FF);
        chk("lbu_rd", resp_rd_a, 5'd3);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised multi-cycle data-memory access unit for the M stage.
- Accepts one load/store per handshake and generates byte enables and lane-aligned write data.
- Optionally splits misaligned half/word accesses into two aligned beats, with a bus timeout.
- Returns sign/zero-extended load data and raises AdEL/AdES/DBE exceptions; the pipeline stalls on req_ready=0.

Parameters:
- ADDR_W, 32, byte-address width (>=3).
- SPLIT_MISALIGN, 1: 1 = split misaligned accesses into two beats; 0 = raise an address exception.
- TIMEOUT, 16: max cycles per beat waiting for gnt+rvalid before DBE (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept (IDLE only).
- req_op  in  3  0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination register.
- resp_valid  out  1  one-cycle pulse: access completed.
- resp_data  out  32  extended load data (0 for stores).
- resp_rd  out  5  rd of the completed op (0 for stores).
- exc_valid  out  1  one-cycle pulse: access aborted.
- exc_code  out  5  4 AdEL, 5 AdES, 7 DBE.
- mem_req  out  1  bus request.
- mem_we  out  1  write.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data / write ack.
- mem_rdata  in  32  read word.

Behaviour:
- Reset state: all outputs 0 except req_ready=1; FSM IDLE; counters and latches cleared.
  - Reset mid-transaction drops the transaction silently.
  - A later mem_rvalid is ignored while IDLE.
- Size: byte=1, half=2, word=4. off=addr[1:0]. Misaligned = (half and off[0]) or (word and off!=0).
- Two-beat access: when misaligned and off+size>4. With SPLIT_MISALIGN=0, any misaligned access is an exception.
- Lane maths:
  - mask = 4'b0001/0011/1111 by size.
  - be64 = {4'b0,mask} << off.
  - wd64 = {32'b0, size-truncated wdata} << 8*off.
  - Beat1: addr = {addr[ADDR_W-1:2],00}, be = be64[3:0], wdata = wd64[31:0].
  - Beat2: addr = beat1 addr + 4 (wraps modulo 2^ADDR_W), be = be64[7:4], wdata = wd64[63:32].
- Load assemble: rd64 = {rdata_beat2, rdata_beat1} >> 8*off. Beat2 word = 0 if single-beat. Truncate to size; sign-extend lb/lh, zero-extend lbu/lhu.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, FAULT.
  - IDLE: on req_valid, latch the request.
    - Misaligned and SPLIT_MISALIGN=0 -> FAULT.
    - Otherwise -> REQ1.
  - REQ1/REQ2: mem_req=1 with stable addr/be/wdata/we until mem_gnt. Gnt -> WAITn.
  - WAIT1: mem_rvalid -> capture rdata. Then REQ2 if two-beat, else IDLE with resp_valid=1 on the following cycle (registered).
  - WAIT2: mem_rvalid -> IDLE with resp_valid pulse.
  - FAULT: one cycle. exc_valid=1, exc_code 4 (load) or 5 (store). -> IDLE. No bus activity.
- Timeout:
  - Per-beat counter is cleared on entering REQn and increments each cycle in REQn/WAITn.
  - On reaching TIMEOUT without rvalid: deassert mem_req, pulse exc_valid with code 7, go to IDLE, drop the request.
  - Beat1 writes already performed are not rolled back.
- Same-cycle events:
  - mem_gnt and mem_rvalid in the same cycle is illegal; rvalid arrives >=1 cycle after gnt.
  - rvalid on the timeout cycle counts as success.
- Latency: a single-beat request accepted at cycle 0 with immediate gnt at 1 and rvalid at 2 gives resp_valid at cycle 3.
- Never: resp_valid and exc_valid together. Never a new request while not IDLE.

Test Plan:
- lb addr 0x103, mem_rdata 0x80FF_1234, gnt/rvalid immediate -> mem_be=1000, mem_addr=0x100, resp_data=0xFFFF_FF80, resp at cycle 3.
- sh addr 0x202, wdata 0xAAAA_BEEF -> mem_we=1, mem_be=1100, mem_wdata[31:16]=0xBEEF, resp_valid pulse, resp_data=0.
- lw addr 0x301, SPLIT=1, rdata 0x44332211 then 0x88776655:
  - beat1 addr 0x300 be=1110; beat2 addr 0x304 be=0001.
  - resp_data=0x55443322.
- lhu addr 0x1, SPLIT=0 -> exc_valid with exc_code=4 on cycle 1, mem_req never asserted. sw addr 0x2 -> exc_code=5.
- sw addr 0x0, mem_gnt held 0, TIMEOUT=16 -> mem_req high 16 cycles, then exc_code=7, req_ready=1.
- reset asserted in WAIT2 of a split load, then a late mem_rvalid -> outputs 0, no resp_valid; the next lbu completes normally.
